sirv_plic_irq_cond: RTL and testbench
=====================================

// Module: sirv_plic_irq_cond
// PURPOSE
//  Interrupt-source conditioning stage directly upstream of the PLIC device inputs (io_devices_0_*).
//  Per source: optional polarity inversion, SYNC_STAGES-flop synchronizer, stability (glitch) filter,
//  then level or rising-edge-pulse output, gated by an enable. Outputs drive PLIC sources 1..IRQ_NUM.
//  One clock domain (PLIC clk); raw inputs may be asynchronous to it.
// PARAMETERS
//  IRQ_NUM      17             number of conditioned sources (PLIC io_devices_0_0..16)
//  SYNC_STAGES  2              synchronizer depth, legal range 2..4
//  FILT_CYCLES  4              consecutive differing samples needed to accept a change, legal range 1..2**FILT_W-1
//  FILT_W       3              filter counter width
//  EDGE_MASK    {IRQ_NUM{1'b0}} bit i=1: source i rising-edge mode (1-cycle pulse); 0: level mode
//  INV_MASK     {IRQ_NUM{1'b0}} bit i=1: raw source i is active-low (inverted before sync)
// PORTS
//  clk          in   1        clock, shared with PLIC
//  rst          in   1        asynchronous, active-high reset
//  irq_raw_i    in   IRQ_NUM  raw device interrupt lines (async)
//  irq_en_i     in   IRQ_NUM  per-source output enable (synchronous to clk)
//  irq_o        out  IRQ_NUM  conditioned interrupts to PLIC io_devices_0_[IRQ_NUM-1:0]
//  irq_state_o  out  IRQ_NUM  filtered (accepted) level per source, ungated, for debug/readback
// BEHAVIOUR
//  - Reset (async assert, sync-free deassert handled upstream): all sync flops, st, cnt, irq_o = 0;
//    irq_state_o = 0. Reset mid-operation discards in-flight filter counts; no pulse emitted on release.
//  - in_i = irq_raw_i[i] ^ INV_MASK[i]; chain sync[0..SYNC_STAGES-1]; s_i = last stage.
//  - Filter, per source, every clk edge:
//      s_i == st_i           -> cnt_i <= 0
//      s_i != st_i, cnt_i <  FILT_CYCLES-1 -> cnt_i <= cnt_i+1
//      s_i != st_i, cnt_i == FILT_CYCLES-1 -> st_i <= s_i, cnt_i <= 0
//    So a change is accepted only after FILT_CYCLES consecutive differing samples; any matching sample
//    restarts the count (glitch shorter than FILT_CYCLES cycles -> no effect, both directions).
//  - st_nxt = next value of st_i. irq_o registered:
//      level mode: irq_o[i] <= irq_en_i[i] & st_nxt
//      edge  mode: irq_o[i] <= irq_en_i[i] & st_nxt & ~st_i   (exactly 1 cycle per accepted rise)
//  - irq_state_o[i] = st_i (register, not gated).
//  - Latency: stable input change in cycle 0 -> st and irq_o change at edge SYNC_STAGES+FILT_CYCLES
//    (defaults: edge 6). Falling edges in level mode have identical latency.
//  - Enable: takes effect at next edge; filter keeps running while disabled. Edge-mode rise accepted
//    while en=0 is lost (not replayed on enable). Level-mode source enabled while st=1 -> irq_o=1 next edge.
//  - Counter never exceeds FILT_CYCLES-1; no wrap. Sources are fully independent; simultaneous changes
//    on any set of sources are handled in parallel with no arbitration.
//  - Input toggling every cycle forever: st never changes, irq_o holds.
// STRUCTURE
//  - Shared package/header (sirv_plic_defines): PLIC_DEV_NUM=17, default SYNC_STAGES/FILT_CYCLES,
//    mode encodings (IRQ_MODE_LEVEL=0, IRQ_MODE_EDGE=1).
//  - Sub-module sirv_irq_cond_chan: one source (sync chain, filter counter, st, output flop),
//    params SYNC_STAGES/FILT_CYCLES/FILT_W/EDGE/INV; top generates IRQ_NUM instances.
//  - Elaboration check: FILT_CYCLES <= 2**FILT_W-1, SYNC_STAGES>=2.
// TESTING
//  1 Reset: hold rst=1, irq_raw_i=all 1 -> irq_o=0, irq_state_o=0; release rst, raw=0 on src with
//    INV_MASK=1 -> irq_o[that src] rises at edge 6.
//  2 Level src0, defaults: raw0 0->1 at cycle 0, en=1 -> irq_o[0]=1 from edge 6; raw0 1->0 -> 0 six edges later.
//  3 Glitch: raw0 high for 3 cycles (FILT_CYCLES=4) -> irq_o[0] stays 0; high for 4 cycles -> 1 at edge 6.
//  4 Edge src5 (EDGE_MASK[5]=1): raw5 held high 20 cycles -> irq_o[5] high exactly 1 cycle at edge 6;
//    irq_state_o[5] high until 6 edges after fall.
//  5 Enable: level src3 st=1 with en=0 -> irq_o[3]=0; set en=1 -> irq_o[3]=1 next edge;
//    edge src5 rise while en=0 -> no pulse after enabling.
//  6 Async reset mid-filter: raw0 high 2 cycles then rst pulse -> all outputs 0 immediately, cnt cleared,
//    after release raw0 held high -> irq_o[0] rises SYNC_STAGES+FILT_CYCLES edges later.

Source files
------------

// File: rtl/sirv_plic_defines.sv
// Shared constants and mode encodings for the PLIC interrupt conditioning stage.
// No ports; imported by sirv_irq_cond_chan and sirv_plic_irq_cond.
package sirv_plic_defines;

    localparam int PLIC_DEV_NUM    = 17;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_CYCLES = 4;
    localparam int DEF_FILT_W      = 3;

    typedef enum logic {
        IRQ_MODE_LEVEL = 1'b0,
        IRQ_MODE_EDGE  = 1'b1
    } irq_mode_e;

    // Legal parameter set: synchronizer 2..4 deep, filter length that
    // fits the counter without ever needing to wrap.
    function automatic bit cfg_ok(input int sync_stages,
                                  input int filt_cycles,
                                  input int filt_w);
        return (sync_stages >= 2) && (sync_stages <= 4) &&
               (filt_cycles >= 1) &&
               (filt_cycles <= (2 ** filt_w) - 1);
    endfunction

endpackage

// File: rtl/sirv_irq_cond_chan.sv
// One interrupt source: polarity, synchronizer, glitch filter, output flop.
// Ports: clk, rst, raw (async line), en (gate), irq (to PLIC), state (filtered level).
module sirv_irq_cond_chan
    import sirv_plic_defines::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int FILT_W      = DEF_FILT_W,
    parameter bit EDGE        = 1'b0,
    parameter bit INV         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic en,
    output logic irq,
    output logic state
);

    localparam logic [FILT_W-1:0] CNT_MAX = FILT_W'(FILT_CYCLES - 1);
    localparam irq_mode_e MODE = irq_mode_e'(EDGE);

    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0]      cnt;
    logic                   st;
    logic                   s;
    logic                   flip;
    logic                   st_nxt;

    assign s = sync[SYNC_STAGES-1];

    // The FILT_CYCLES-th consecutive differing sample is accepted.
    assign flip   = (s != st) && (cnt == CNT_MAX);
    assign st_nxt = flip ? s : st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            st   <= 1'b0;
            irq  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw ^ INV};
            // A matching sample restarts the run of differing samples.
            if ((s == st) || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            st <= st_nxt;
            if (MODE == IRQ_MODE_EDGE) begin
                irq <= en & st_nxt & ~st;
            end else begin
                irq <= en & st_nxt;
            end
        end
    end

    assign state = st;

endmodule

// File: rtl/sirv_plic_irq_cond.sv
// Interrupt-source conditioning in front of the PLIC device inputs.
// Ports: clk, rst, irq_raw_i, irq_en_i in; irq_o (to PLIC), irq_state_o (filtered, ungated) out.
module sirv_plic_irq_cond
    import sirv_plic_defines::*;
#(
    parameter int                 IRQ_NUM     = PLIC_DEV_NUM,
    parameter int                 SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int                 FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int                 FILT_W      = DEF_FILT_W,
    parameter logic [IRQ_NUM-1:0] EDGE_MASK   = '0,
    parameter logic [IRQ_NUM-1:0] INV_MASK    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq_raw_i,
    input  logic [IRQ_NUM-1:0] irq_en_i,
    output logic [IRQ_NUM-1:0] irq_o,
    output logic [IRQ_NUM-1:0] irq_state_o
);

    if (!cfg_ok(SYNC_STAGES, FILT_CYCLES, FILT_W)) begin : g_bad_cfg
        $error("sirv_plic_irq_cond: illegal SYNC_STAGES/FILT_CYCLES/FILT_W");
    end

    for (genvar i = 0; i < IRQ_NUM; i++) begin : g_chan
        sirv_irq_cond_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .FILT_W      (FILT_W),
            .EDGE        (EDGE_MASK[i]),
            .INV         (INV_MASK[i])
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (irq_raw_i[i]),
            .en    (irq_en_i[i]),
            .irq   (irq_o[i]),
            .state (irq_state_o[i])
        );
    end

endmodule

// File: tb/tb_sirv_plic_irq_cond.sv
// Scoreboarded bench for sirv_plic_irq_cond with a window-based reference model.
// Directed latency/glitch/enable/reset scenarios followed by random traffic.
module tb_sirv_plic_irq_cond;

    localparam int N = 17;
    localparam int S = 2;
    localparam int F = 4;
    localparam int W = 3;
    localparam logic [N-1:0] EM  = 17'h00020;
    localparam logic [N-1:0] INV = 17'h00080;
    localparam logic [N-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] en;
    logic [N-1:0] irq_o;
    logic [N-1:0] st_o;

    always #5 clk = ~clk;

    sirv_plic_irq_cond #(
        .IRQ_NUM     (N),
        .SYNC_STAGES (S),
        .FILT_CYCLES (F),
        .FILT_W      (W),
        .EDGE_MASK   (EM),
        .INV_MASK    (INV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_raw_i   (raw),
        .irq_en_i    (en),
        .irq_o       (irq_o),
        .irq_state_o (st_o)
    );

    int checks   = 0;
    int failures = 0;

    logic [2*N-1:0] expq[$];

    // Reference: input delayed S edges is the sample; the accepted level
    // flips when the last F samples all differ from it.
    logic [N-1:0] m_st;
    logic [31:0]  ih[N];
    logic [31:0]  sh[N];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [N-1:0] r,
                                  input logic [N-1:0] e,
                                  input logic rs);
        logic [N-1:0] nst;
        logic [N-1:0] ir;
        logic         samp;
        logic         dif;
        nst = '0;
        ir  = '0;
        if (rs) begin
            m_st = '0;
            for (int i = 0; i < N; i++) begin
                ih[i] = '0;
                sh[i] = '0;
            end
            expq.push_back('0);
            return;
        end
        for (int i = 0; i < N; i++) begin
            samp  = ih[i][S-1];
            ih[i] = {ih[i][30:0], r[i] ^ INV[i]};
            sh[i] = {sh[i][30:0], samp};
            dif   = 1'b1;
            for (int k = 0; k < F; k++)
                if (sh[i][k] == m_st[i]) dif = 1'b0;
            nst[i] = dif ? ~m_st[i] : m_st[i];
            ir[i]  = e[i] & nst[i] & (EM[i] ? ~m_st[i] : 1'b1);
        end
        expq.push_back({ir, nst});
        m_st = nst;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] e,
                        input logic rs);
        @(negedge clk);
        rst = rs;
        raw = r;
        en  = e;
        model(r, e, rs);
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] e);
        step(r, e, 1'b0);
        @(posedge clk);
        #2;
    endtask

    task automatic hold_until(input int idx, input logic want,
                              input logic [N-1:0] r, input logic [N-1:0] e,
                              input int maxn, output int n);
        n = maxn + 1;
        for (int k = 1; k <= maxn; k++) begin
            tick(r, e);
            if (irq_o[idx] == want) begin
                n = k;
                break;
            end
        end
    endtask

    // Monitor: every edge with an outstanding expectation is compared.
    initial begin
        logic [2*N-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sb", {irq_o, st_o}, e);
            end
        end
    end

    initial begin
        int n;
        int cnt1;
        int first;
        int fall;
        logic seen;
        logic [N-1:0] r;
        logic [N-1:0] e;
        logic rs;

        rst  = 1'b1;
        raw  = '1;
        en   = '1;
        m_st = '0;
        for (int i = 0; i < N; i++) begin
            ih[i] = '0;
            sh[i] = '0;
        end

        // 1: reset with all raw lines high, release with inverted source
        repeat (3) step(ONES, ONES, 1'b1);
        @(posedge clk);
        #2;
        chk("rst_irq", irq_o, 0);
        chk("rst_state", st_o, 0);
        hold_until(7, 1'b1, '0, ONES, 12, n);
        chk("t1_inv_lat", n, 6);
        repeat (8) tick('0, ONES);

        // 2: level source 0 rise and fall latency
        hold_until(0, 1'b1, 17'h1, ONES, 12, n);
        chk("t2_rise_lat", n, 6);
        hold_until(0, 1'b0, '0, ONES, 12, n);
        chk("t2_fall_lat", n, 6);
        repeat (8) tick('0, ONES);

        // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
        seen = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick((k <= 3) ? 17'h1 : 17'h0, ONES);
            seen = seen | irq_o[0] | st_o[0];
        end
        chk("t3_glitch", seen, 0);
        first = 0;
        for (int k = 1; k <= 14; k++) begin
            tick((k <= 4) ? 17'h1 : 17'h0, ONES);
            if (first == 0 && irq_o[0]) first = k;
        end
        chk("t3_pulse4", first, 6);
        repeat (8) tick('0, ONES);

        // 4: edge-mode source 5 emits a single pulse
        cnt1  = 0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(17'h20, ONES);
            if (irq_o[5]) begin
                cnt1++;
                if (first == 0) first = k;
            end
        end
        chk("t4_pulses", cnt1, 1);
        chk("t4_first", first, 6);
        chk("t4_state_hi", st_o[5], 1);
        fall = 0;
        for (int k = 1; k <= 12; k++) begin
            tick('0, ONES);
            if (fall == 0 && !st_o[5]) fall = k;
        end
        chk("t4_state_fall", fall, 6);
        repeat (4) tick('0, ONES);

        // 5: enable gating, level replay and edge loss
        repeat (8) tick(17'h8, ~17'h8);
        chk("t5_gated", irq_o[3], 0);
        chk("t5_st3", st_o[3], 1);
        hold_until(3, 1'b1, 17'h8, ONES, 4, n);
        chk("t5_en_lat", n, 1);
        repeat (10) tick(17'h28, ~17'h20);
        cnt1 = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(17'h28, ONES);
            if (irq_o[5]) cnt1++;
        end
        chk("t5_edge_lost", cnt1, 0);
        repeat (10) tick(17'h8, ONES);

        // 6: asynchronous reset in the middle of a filter run
        repeat (2) tick(17'h9, ONES);
        step(17'h9, ONES, 1'b1);
        #1;
        chk("t6_irq", irq_o, 0);
        chk("t6_state", st_o, 0);
        hold_until(0, 1'b1, 17'h9, ONES, 12, n);
        chk("t6_lat", n, 6);
        repeat (8) tick('0, ONES);

        // Random traffic: sparse flips give both glitches and long runs.
        r = '0;
        e = ONES;
        for (int k = 0; k < 3000; k++) begin
            r = r ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) e = N'($urandom);
            rs = ($urandom_range(0, 299) == 0);
            step(r, e, rs);
        end

        @(posedge clk);
        #3;
        chk("sb_drain", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
